exec_issue_ctrl: RTL
====================

Name: exec_issue_ctrl

Overview:
- Issue controller and scoreboard in front of the execute stage.
- Accepts one decoded instruction per cycle from decode through a valid/ready handshake. Tracks pending register writebacks (two destination ports, matching the dual-result ALU) and in-flight status-flag writers.
- Holds the instruction at decode until no RAW/WAW register hazard and no flag hazard exists, and the execute stage is ready.
- Writeback and flag-retire pulses from later stages clear pending state.

Parameters:
NREG, 32, number of architectural registers tracked (address width 5)
FLG_MAX, 3, maximum in-flight flag-writing instructions; flag counter width is clog2(FLG_MAX+1)
CNT_W, 16, width of saturating stall-cycle counter

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
id_valid  input  1  decode presents an instruction
id_ready  output  1  controller accepts it this cycle (combinational)
id_sa, id_sb  input  5 each  source register addresses
id_use_a, id_use_b  input  1 each  source is actually read
id_da1, id_da2  input  5 each  destination addresses (result 1 / result 2)
id_we1, id_we2  input  1 each  destination write enables
id_rd_flags  input  1  instruction is conditional (reads status)
id_wr_flags  input  1  instruction writes any of n/z/c/v
ex_ready  input  1  execute stage can take an instruction
ex_issue  output  1  instruction issued this cycle (= id_valid & id_ready)
wb_we1, wb_we2  input  1 each  writeback retire strobes
wb_a1, wb_a2  input  5 each  retiring register addresses
flg_ret  input  1  one flag-writing instruction has committed its flags
flush  input  1  synchronous pipeline flush
busy  output  NREG  registered scoreboard (bit i = register i pending)
flg_cnt  output  clog2(FLG_MAX+1)  in-flight flag writers
stall_cnt  output  CNT_W  saturating count of cycles with id_valid & ~id_ready
err  output  1  sticky protocol error

Behaviour:
- Reset (async): busy=0, flg_cnt=0, stall_cnt=0, err=0. id_ready and ex_issue are combinational; with id_valid=0 both are 0.
- Hazards use registered state only (no same-cycle retire bypass):
  - raw = (id_use_a & busy[id_sa]) | (id_use_b & busy[id_sb])
  - waw = (id_we1 & busy[id_da1]) | (id_we2 & busy[id_da2])
  - fhz = (id_rd_flags & flg_cnt!=0) | (id_wr_flags & flg_cnt==FLG_MAX)
- id_ready = ex_ready & ~flush & ~raw & ~waw & ~fhz. Decode must hold inputs stable while id_valid & ~id_ready.
- On ex_issue at a clock edge:
  - set busy[id_da1] if id_we1; set busy[id_da2] if id_we2.
  - id_we1 & id_we2 with id_da1==id_da2: set the bit once and assert err.
  - flg_cnt += id_wr_flags.
- Retire at the same edge:
  - clear busy[wb_a1] if wb_we1; clear busy[wb_a2] if wb_we2.
  - flg_cnt -= flg_ret.
  - Issue increment and flg_ret in the same cycle: net count unchanged.
- Set and clear of the same bit in one cycle: set wins (new writer pending). This is unreachable under legal WAW stalling but is defined anyway.
- Retire of a non-busy register, or flg_ret with flg_cnt==0: state unchanged, err<=1.
- err clears only on rst.
- flush (sync, one or more cycles):
  - next state busy=0, flg_cnt=0.
  - No issue in a flush cycle.
  - Retires in the same cycle are ignored and flag no error.
  - stall_cnt is not incremented in a flush cycle.
- stall_cnt: increments each cycle id_valid & ~id_ready & ~flush; saturates at all-ones.
- Latency: zero-cycle issue when hazard-free. A dependent instruction issues in the cycle after the edge at which its producer's retire strobe is sampled.
- Reset mid-operation discards all pending state immediately. Downstream stages are reset by the same rst.

Decomposition:
- Shared package holds:
  - register-address width (5)
  - NREG
  - FLG_MAX default
  - hazard-cause encoding for debug: HZ_NONE, HZ_RAW, HZ_WAW, HZ_FLG, HZ_EXBUSY
- One sub-module, exec_scoreboard: the NREG-bit busy vector with two set ports, two clear ports, flush, and the set-wins rule.
- Hazard logic, flag counter and stall counter stay in exec_issue_ctrl.

Test Plan:
- Reset, then id_valid with id_use_a, id_sa=3, id_we1, id_da1=5, ex_ready=1 -> ex_issue=1 same cycle; next cycle busy=0x20.
- busy[5] set, new instruction id_use_b, id_sb=5 -> id_ready=0, stall_cnt increments each cycle. wb_we1, wb_a1=5 pulsed -> id_ready=1 in the following cycle.
- Flag writer issued (flg_cnt=1), then conditional id_rd_flags=1 -> stalled until flg_ret. Issuing three flag writers with no retire -> fourth stalled (flg_cnt=3). Issue plus flg_ret in the same cycle -> count unchanged.
- Issue writing da1=7 while wb retires a1=7 (busy[7]=0 beforehand) -> err=1 and busy[7]=1 next cycle (set wins).
- busy=0x00F0, flg_cnt=2, flush=1 for one cycle with id_valid=1 -> id_ready=0; next cycle busy=0, flg_cnt=0, stall_cnt unchanged.
- Hold a stall for 2^CNT_W+5 cycles -> stall_cnt saturates at 0xFFFF. Assert rst mid-stall -> all outputs return to 0 asynchronously.

Source files
------------

// File: rtl/exec_issue_ctrl_pkg.sv
// Shared constants and debug encodings for the execute issue controller.
// Imported by the scoreboard and the issue control top.
package exec_issue_ctrl_pkg;

  localparam int ADDR_W      = 5;
  localparam int NREG_DEF    = 32;
  localparam int FLG_MAX_DEF = 3;

  typedef enum logic [2:0] {
    HZ_NONE,
    HZ_RAW,
    HZ_WAW,
    HZ_FLG,
    HZ_EXBUSY
  } hz_e;

endpackage

// File: rtl/exec_scoreboard.sv
// Pending-writeback busy vector: two set ports, two clear ports, flush.
// A set and a clear of the same bit in one cycle leaves it set.
module exec_scoreboard
  import exec_issue_ctrl_pkg::*;
#(
  parameter int NREG = NREG_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              set1,
  input  logic [ADDR_W-1:0] set_a1,
  input  logic              set2,
  input  logic [ADDR_W-1:0] set_a2,
  input  logic              clr1,
  input  logic [ADDR_W-1:0] clr_a1,
  input  logic              clr2,
  input  logic [ADDR_W-1:0] clr_a2,
  output logic [NREG-1:0]   busy
);

  logic [NREG-1:0] set_m;
  logic [NREG-1:0] clr_m;
  logic [NREG-1:0] busy_nxt;

  always_comb begin
    set_m = '0;
    clr_m = '0;
    if (set1) set_m[set_a1] = 1'b1;
    if (set2) set_m[set_a2] = 1'b1;
    if (clr1) clr_m[clr_a1] = 1'b1;
    if (clr2) clr_m[clr_a2] = 1'b1;
    busy_nxt = flush ? '0 : ((busy & ~clr_m) | set_m);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

endmodule

// File: rtl/exec_issue_ctrl.sv
// Issue gate in front of execute: register/flag hazard checks,
// in-flight flag counter, stall counter and sticky protocol error.
module exec_issue_ctrl
  import exec_issue_ctrl_pkg::*;
#(
  parameter int NREG    = NREG_DEF,
  parameter int FLG_MAX = FLG_MAX_DEF,
  parameter int CNT_W   = 16,
  localparam int FW     = $clog2(FLG_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [ADDR_W-1:0] id_sa,
  input  logic [ADDR_W-1:0] id_sb,
  input  logic              id_use_a,
  input  logic              id_use_b,
  input  logic [ADDR_W-1:0] id_da1,
  input  logic [ADDR_W-1:0] id_da2,
  input  logic              id_we1,
  input  logic              id_we2,
  input  logic              id_rd_flags,
  input  logic              id_wr_flags,
  input  logic              ex_ready,
  output logic              ex_issue,
  input  logic              wb_we1,
  input  logic              wb_we2,
  input  logic [ADDR_W-1:0] wb_a1,
  input  logic [ADDR_W-1:0] wb_a2,
  input  logic              flg_ret,
  input  logic              flush,
  output logic [NREG-1:0]   busy,
  output logic [FW-1:0]     flg_cnt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic              err
);

  localparam logic [FW-1:0] FMAX = FW'(FLG_MAX);

  logic raw, waw, fhz, ex_blk;
  hz_e  hz_cause;

  assign raw = (id_use_a & busy[id_sa])
             | (id_use_b & busy[id_sb]);
  assign waw = (id_we1 & busy[id_da1])
             | (id_we2 & busy[id_da2]);
  assign fhz = (id_rd_flags & (flg_cnt != '0))
             | (id_wr_flags & (flg_cnt == FMAX));
  // Nothing issues while reset is held, so the handshake is quiet too.
  assign ex_blk = ~ex_ready | flush | rst;

  always_comb begin
    hz_cause = HZ_NONE;
    if      (ex_blk) hz_cause = HZ_EXBUSY;
    else if (raw)    hz_cause = HZ_RAW;
    else if (waw)    hz_cause = HZ_WAW;
    else if (fhz)    hz_cause = HZ_FLG;
  end

  assign id_ready = (hz_cause == HZ_NONE);
  assign ex_issue = id_valid & id_ready;

  logic flg_inc, flg_dec, dup_dst, bad_ret, stall;

  assign flg_inc = ex_issue & id_wr_flags;
  assign flg_dec = flg_ret & ~flush & (flg_cnt != '0);
  assign dup_dst = ex_issue & id_we1 & id_we2
                 & (id_da1 == id_da2);
  assign bad_ret = ~flush & ((wb_we1 & ~busy[wb_a1])
                 | (wb_we2 & ~busy[wb_a2])
                 | (flg_ret & (flg_cnt == '0)));
  assign stall   = id_valid & ~id_ready & ~flush;

  exec_scoreboard #(
    .NREG (NREG)
  ) u_sb (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .set1   (ex_issue & id_we1),
    .set_a1 (id_da1),
    .set2   (ex_issue & id_we2),
    .set_a2 (id_da2),
    .clr1   (wb_we1 & ~flush),
    .clr_a1 (wb_a1),
    .clr2   (wb_we2 & ~flush),
    .clr_a2 (wb_a2),
    .busy   (busy)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flg_cnt   <= '0;
      stall_cnt <= '0;
      err       <= 1'b0;
    end else begin
      if (flush) flg_cnt <= '0;
      else       flg_cnt <= flg_cnt + FW'(flg_inc) - FW'(flg_dec);
      if (stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
      if (dup_dst || bad_ret)
        err <= 1'b1;
    end
  end

endmodule
